seg7_scan_decoder: RTL and testbench
====================================

// Module: seg7_scan_decoder
// PURPOSE
//  Receive-side counterpart of the hex-to-7-segment encoder. Samples a time-multiplexed
//  7-segment display bus (segment lines + one-hot digit select), filters glitches per digit,
//  decodes each stable pattern back to a 4-bit hex nibble and assembles a full display word.
//  Sits between a scanned display bus (or display-driver loopback) and a host that consumes words.
// PARAMETERS
//  NUM_DIGITS     4  number of multiplexed digits; word width = 4*NUM_DIGITS
//  STABLE_CYCLES  3  consecutive identical sample_en samples (same dig_sel, same seg_in) to commit a digit; >=1
// PORTS
//  clk         in   1             single clock; all logic rising-edge
//  reset       in   1             synchronous, active-high
//  sample_en   in   1             sample strobe; bus sampled only when high
//  seg_in      in   7             segments {a,b,c,d,e,f,g}, bit6=a .. bit0=g, active-high
//  dig_sel     in   NUM_DIGITS    one-hot active-high digit select; bit0 = least significant nibble
//  word_out    out  4*NUM_DIGITS  decoded word; nibble i from digit i
//  blank_mask  out  NUM_DIGITS    bit i set = digit i was blank (seg 0000000), nibble forced to 0
//  frame_err   out  1             >=1 digit in the frame held a non-hex, non-blank pattern
//  word_valid  out  1             word_out/blank_mask/frame_err valid; held until accepted
//  word_ready  in   1             consumer accept; transfer when word_valid & word_ready
//  overrun     out  1             1-cycle pulse: a completed frame was dropped (output still held)
// BEHAVIOUR
//  Reset: word_out=0, blank_mask=0, frame_err=0, word_valid=0, overrun=0; stability counter=0,
//   prev sample regs=0, captured mask=0, capture regs=0, state=COLLECT. Reset mid-frame drops partial frame.
//  Decode table (seg_in -> nibble): 7E->0 30->1 6D->2 79->3 33->4 5B->5 5F->6 70->7 7F->8 7B->9
//   77->A 1F->B 4E->C 3D->D 4F->E 47->F. 00 -> blank. Any other code -> invalid (nibble 0, err).
//  Sampling (only on sample_en=1):
//   - dig_sel not one-hot (zero or multi-bit): sample ignored, counter cleared to 0, prev regs cleared.
//   - same dig_sel and seg_in as previous accepted sample: counter+1, saturating at STABLE_CYCLES.
//   - otherwise counter=1, prev regs <= sample.
//   - commit occurs on the sample where counter becomes exactly STABLE_CYCLES (once per stable run;
//     STABLE_CYCLES=1 commits every changed sample). Commit writes nibble, blank bit, invalid bit
//     for that digit into capture regs and sets its captured bit.
//   - re-commit of an already captured digit in the same frame overwrites it (latest wins).
//  Frame complete: captured mask all-ones after a commit. Capture regs (nibbles, blank, OR of invalid
//   bits) then go to output stage and captured mask/invalid bits clear in the same cycle.
//  State machine (output stage):
//   COLLECT: word_valid=0. On frame complete -> load outputs, word_valid=1 next cycle -> HOLD.
//   HOLD: outputs stable. word_ready=1 -> word_valid=0, -> COLLECT (same-cycle completion while
//     word_ready=1: new frame loads, stays HOLD, no overrun). Frame complete while word_ready=0:
//     frame discarded, overrun=1 for one cycle, outputs unchanged, stays HOLD.
//  Latency: word_valid rises the cycle after the clock edge sampling the completing sample_en.
//  Collection of the next frame continues during HOLD; sample_en=0 freezes all sampling state.
// TESTING
//  1. NUM_DIGITS=4, STABLE=3: scan digits 0..3 with 5B,79,6D,30 each 3 samples -> word_out=16'h1235,
//     blank_mask=0, frame_err=0, word_valid high next cycle; word_ready=1 -> word_valid drops.
//  2. Glitch: digit0 sees 7E,7E,7F,7E,7E,7E -> commits once as 0 (two-sample run never commits).
//  3. Digit2 shows 00, digit3 shows 0x01 -> blank_mask=4'b0100, frame_err=1, nibbles 2,3 = 0.
//  4. Hold word_ready=0, complete two frames -> first word held, overrun pulses 1 cycle on second.
//  5. dig_sel=4'b0011 mid-run -> counter clears; digit needs 3 fresh samples to commit.
//  6. Reset asserted after 3 of 4 digits captured -> outputs 0; next frame needs all 4 digits again.

Source files
------------

// File: rtl/seg7_scan_decoder.sv
// Scanned 7-segment bus receiver: per-digit glitch filter, segment-to-hex decode and
// frame assembly into a held output word with valid/ready handshake and overrun flag.
module seg7_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sample_en,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  output logic [4*NUM_DIGITS-1:0] word_out,
  output logic [NUM_DIGITS-1:0]   blank_mask,
  output logic                    frame_err,
  output logic                    word_valid,
  input  logic                    word_ready,
  output logic                    overrun
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] STABLE_MAX = CW'(STABLE_CYCLES);
  localparam logic [NUM_DIGITS-1:0] SEL_ONE = NUM_DIGITS'(1);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  // segment decode
  logic [3:0] dec_nib;
  logic       dec_blank;
  logic       dec_inv;

  always_comb begin
    dec_nib   = 4'h0;
    dec_blank = 1'b0;
    dec_inv   = 1'b0;
    case (seg_in)
      7'h7E: dec_nib = 4'h0;
      7'h30: dec_nib = 4'h1;
      7'h6D: dec_nib = 4'h2;
      7'h79: dec_nib = 4'h3;
      7'h33: dec_nib = 4'h4;
      7'h5B: dec_nib = 4'h5;
      7'h5F: dec_nib = 4'h6;
      7'h70: dec_nib = 4'h7;
      7'h7F: dec_nib = 4'h8;
      7'h7B: dec_nib = 4'h9;
      7'h77: dec_nib = 4'hA;
      7'h1F: dec_nib = 4'hB;
      7'h4E: dec_nib = 4'hC;
      7'h3D: dec_nib = 4'hD;
      7'h4F: dec_nib = 4'hE;
      7'h47: dec_nib = 4'hF;
      7'h00: dec_blank = 1'b1;
      default: dec_inv = 1'b1;
    endcase
  end

  // glitch filter
  logic [CW-1:0]         cnt_reg, cnt_next;
  logic [NUM_DIGITS-1:0] prev_sel_reg, prev_sel_next;
  logic [6:0]            prev_seg_reg, prev_seg_next;
  logic                  sel_onehot;
  logic                  same_sample;
  logic                  commit;

  assign sel_onehot  = (dig_sel != '0) && ((dig_sel & (dig_sel - SEL_ONE)) == '0);
  assign same_sample = (dig_sel == prev_sel_reg) && (seg_in == prev_seg_reg);

  always_comb begin
    cnt_next      = cnt_reg;
    prev_sel_next = prev_sel_reg;
    prev_seg_next = prev_seg_reg;
    commit        = 1'b0;
    if (sample_en) begin
      if (!sel_onehot) begin
        cnt_next      = '0;
        prev_sel_next = '0;
        prev_seg_next = '0;
      end else if (same_sample) begin
        // saturation keeps a long stable run from committing more than once
        if (cnt_reg != STABLE_MAX) begin
          cnt_next = cnt_reg + CNT_ONE;
          commit   = (cnt_reg == (STABLE_MAX - CNT_ONE));
        end
      end else begin
        cnt_next      = CNT_ONE;
        prev_sel_next = dig_sel;
        prev_seg_next = seg_in;
        commit        = (STABLE_CYCLES == 1);
      end
    end
  end

  // frame capture
  logic [4*NUM_DIGITS-1:0] cap_nib_reg, cap_nib_upd;
  logic [NUM_DIGITS-1:0]   cap_blank_reg, cap_blank_upd;
  logic [NUM_DIGITS-1:0]   cap_inv_reg, cap_inv_upd, cap_inv_next;
  logic [NUM_DIGITS-1:0]   cap_mask_reg, cap_mask_upd, cap_mask_next;
  logic [NUM_DIGITS-1:0]   cap_hit;
  logic                    frame_done;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign cap_hit[gi]            = commit && dig_sel[gi];
      assign cap_nib_upd[gi*4 +: 4] = cap_hit[gi] ? dec_nib : cap_nib_reg[gi*4 +: 4];
      assign cap_blank_upd[gi]      = cap_hit[gi] ? dec_blank : cap_blank_reg[gi];
      assign cap_inv_upd[gi]        = cap_hit[gi] ? dec_inv : cap_inv_reg[gi];
      assign cap_mask_upd[gi]       = cap_mask_reg[gi] | cap_hit[gi];
    end
  endgenerate

  assign frame_done    = commit && (&cap_mask_upd);
  assign cap_mask_next = frame_done ? '0 : cap_mask_upd;
  assign cap_inv_next  = frame_done ? '0 : cap_inv_upd;

  // output stage
  state_t                  state_reg, state_next;
  logic                    load;
  logic                    overrun_next;
  logic [4*NUM_DIGITS-1:0] word_reg;
  logic [NUM_DIGITS-1:0]   blank_reg;
  logic                    err_reg;
  logic                    overrun_reg;

  always_comb begin
    state_next   = state_reg;
    load         = 1'b0;
    overrun_next = 1'b0;
    case (state_reg)
      COLLECT: begin
        if (frame_done) begin
          load       = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (word_ready) begin
          if (frame_done) begin
            load = 1'b1;
          end else begin
            state_next = COLLECT;
          end
        end else if (frame_done) begin
          overrun_next = 1'b1;
        end
      end
      default: state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg       <= '0;
      prev_sel_reg  <= '0;
      prev_seg_reg  <= '0;
      cap_nib_reg   <= '0;
      cap_blank_reg <= '0;
      cap_inv_reg   <= '0;
      cap_mask_reg  <= '0;
      state_reg     <= COLLECT;
      word_reg      <= '0;
      blank_reg     <= '0;
      err_reg       <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      cnt_reg       <= cnt_next;
      prev_sel_reg  <= prev_sel_next;
      prev_seg_reg  <= prev_seg_next;
      cap_nib_reg   <= cap_nib_upd;
      cap_blank_reg <= cap_blank_upd;
      cap_inv_reg   <= cap_inv_next;
      cap_mask_reg  <= cap_mask_next;
      state_reg     <= state_next;
      overrun_reg   <= overrun_next;
      if (load) begin
        word_reg  <= cap_nib_upd;
        blank_reg <= cap_blank_upd;
        err_reg   <= |cap_inv_upd;
      end
    end
  end

  assign word_out   = word_reg;
  assign blank_mask = blank_reg;
  assign frame_err  = err_reg;
  assign word_valid = (state_reg == HOLD);
  assign overrun    = overrun_reg;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder: stimulus queues expected words, a monitor
// pops and compares on every accepted transfer.
module tb_seg7_scan_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_en;
  logic [6:0]  seg_in;
  logic [3:0]  dig_sel;
  logic [15:0] word_out;
  logic [3:0]  blank_mask;
  logic        frame_err;
  logic        word_valid;
  logic        word_ready;
  logic        overrun;

  seg7_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .sample_en  (sample_en),
    .seg_in     (seg_in),
    .dig_sel    (dig_sel),
    .word_out   (word_out),
    .blank_mask (blank_mask),
    .frame_err  (frame_err),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] word;
    logic [3:0]  blank;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;
  int   overrun_cycles = 0;
  int   oc0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // monitor: a transfer happens at the next rising edge whenever valid & ready here
  always @(negedge clk) begin
    if (!reset && word_valid && word_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_word: got %h, required no transfer", word_out);
      end else begin
        mon_e = exp_q.pop_front();
        check("word_out", {16'h0, word_out}, {16'h0, mon_e.word});
        check("blank_mask", {28'h0, blank_mask}, {28'h0, mon_e.blank});
        check("frame_err", {31'h0, frame_err}, {31'h0, mon_e.err});
      end
    end
    if (overrun) overrun_cycles++;
  end

  task automatic samp(input logic [3:0] sel, input logic [6:0] seg);
    sample_en = 1'b1;
    dig_sel   = sel;
    seg_in    = seg;
    @(posedge clk);
    #1;
  endtask

  task automatic scan(input int d, input logic [6:0] seg, input int n);
    logic [3:0] sel;
    sel = 4'(1) << d;
    repeat (n) samp(sel, seg);
  endtask

  task automatic idle(input int n);
    sample_en = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [15:0] w, input logic [3:0] b, input logic e);
    exp_t x;
    x.word  = w;
    x.blank = b;
    x.err   = e;
    exp_q.push_back(x);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset      = 1'b1;
    sample_en  = 1'b0;
    word_ready = 1'b0;
    seg_in     = 7'h00;
    dig_sel    = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_word", {16'h0, word_out}, 32'h0);
    check("reset_blank", {28'h0, blank_mask}, 32'h0);
    check("reset_err", {31'h0, frame_err}, 32'h0);
    check("reset_valid", {31'h0, word_valid}, 32'h0);
    check("reset_overrun", {31'h0, overrun}, 32'h0);

    // basic frame, latency and hold
    push(16'h1235, 4'b0000, 1'b0);
    scan(0, 7'h5B, 3);
    scan(1, 7'h79, 3);
    scan(2, 7'h6D, 3);
    scan(3, 7'h30, 2);
    check("t1_valid_before", {31'h0, word_valid}, 32'h0);
    scan(3, 7'h30, 1);
    check("t1_latency", {31'h0, word_valid}, 32'h1);
    check("t1_word_direct", {16'h0, word_out}, 32'h1235);
    idle(2);
    check("t1_held", {31'h0, word_valid}, 32'h1);
    word_ready = 1'b1;
    idle(1);
    check("t1_drop", {31'h0, word_valid}, 32'h0);

    // glitch filter, digit 0 last so commit timing is visible
    push(16'hAFE0, 4'b0000, 1'b0);
    scan(1, 7'h4F, 3);
    scan(2, 7'h47, 3);
    scan(3, 7'h77, 3);
    samp(4'b0001, 7'h7E);
    samp(4'b0001, 7'h7E);
    samp(4'b0001, 7'h7F);
    samp(4'b0001, 7'h7E);
    samp(4'b0001, 7'h7E);
    check("t2_glitch_no_commit", {31'h0, word_valid}, 32'h0);
    samp(4'b0001, 7'h7E);
    check("t2_commit", {31'h0, word_valid}, 32'h1);
    // continuing a saturated run must not re-commit digit 0
    scan(0, 7'h7E, 3);
    push(16'hCBD0, 4'b0000, 1'b0);
    scan(1, 7'h3D, 3);
    scan(2, 7'h1F, 3);
    scan(3, 7'h4E, 3);
    check("t2_no_recommit", {31'h0, word_valid}, 32'h0);
    scan(0, 7'h7E, 3);
    check("t2_second_frame", {31'h0, word_valid}, 32'h1);

    // blank and invalid digits, latest commit wins
    push(16'h0098, 4'b0100, 1'b1);
    scan(0, 7'h4E, 3);
    scan(0, 7'h7F, 3);
    scan(1, 7'h7B, 3);
    scan(2, 7'h00, 3);
    scan(3, 7'h01, 3);
    idle(2);

    // overrun while held
    word_ready = 1'b0;
    push(16'h3210, 4'b0000, 1'b0);
    scan(0, 7'h7E, 3);
    scan(1, 7'h30, 3);
    scan(2, 7'h6D, 3);
    scan(3, 7'h79, 3);
    check("t4_valid", {31'h0, word_valid}, 32'h1);
    oc0 = overrun_cycles;
    scan(0, 7'h33, 3);
    scan(1, 7'h5B, 3);
    scan(2, 7'h5F, 3);
    scan(3, 7'h70, 2);
    check("t4_no_early_overrun", {31'h0, overrun}, 32'h0);
    scan(3, 7'h70, 1);
    check("t4_overrun_pulse", {31'h0, overrun}, 32'h1);
    idle(1);
    check("t4_overrun_cleared", {31'h0, overrun}, 32'h0);
    check("t4_overrun_cycles", overrun_cycles - oc0, 32'h1);
    check("t4_held_word", {16'h0, word_out}, 32'h3210);
    word_ready = 1'b1;
    idle(1);
    check("t4_drop", {31'h0, word_valid}, 32'h0);

    // non-one-hot select clears the filter
    push(16'h1115, 4'b0000, 1'b0);
    scan(1, 7'h30, 3);
    scan(2, 7'h30, 3);
    scan(3, 7'h30, 3);
    samp(4'b0001, 7'h5B);
    samp(4'b0001, 7'h5B);
    samp(4'b0011, 7'h5B);
    samp(4'b0001, 7'h5B);
    check("t5_fresh1", {31'h0, word_valid}, 32'h0);
    samp(4'b0001, 7'h5B);
    check("t5_fresh2", {31'h0, word_valid}, 32'h0);
    samp(4'b0001, 7'h5B);
    check("t5_commit", {31'h0, word_valid}, 32'h1);

    // reset mid-frame
    scan(0, 7'h30, 3);
    scan(1, 7'h30, 3);
    scan(2, 7'h30, 3);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    check("t6_reset_word", {16'h0, word_out}, 32'h0);
    check("t6_reset_valid", {31'h0, word_valid}, 32'h0);
    scan(3, 7'h4F, 3);
    check("t6_partial_dropped", {31'h0, word_valid}, 32'h0);
    push(16'hE321, 4'b0000, 1'b0);
    scan(0, 7'h30, 3);
    scan(1, 7'h6D, 3);
    scan(2, 7'h79, 3);
    check("t6_complete", {31'h0, word_valid}, 32'h1);
    idle(3);

    check("queue_drained", exp_q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
